// File: rtl/add32_seq_ctrl.sv
// add32_seq_ctrl
//   Sequences a W-bit add (or subtract) through one shared 4-bit
//   carry-lookahead slice, one nibble per clock, LS nibble first.
//   Operands are latched on an accepted start. The inter-nibble carry is
//   formed from the slice's group generate/propagate. The result is
//   assembled nibble by nibble.
//
//   Optional feature macro: ADD32_SUB_EN
//     defined   : sub=1 at accept computes A-B (B' = ~b, carry-in forced to 1)
//     undefined : sub is ignored, B' = b, carry-in = cin
//
// Ports
//   clk_i, rst_i        clock; synchronous active-high reset
//   start_i             request, accepted while busy_o=0
//   a_i, b_i            operands, sampled on the accepting edge
//   cin_i, sub_i        carry-in / subtract request, sampled on the accepting edge
//   busy_o              high while the slice is being sequenced (RUN)
//   done_o              one-cycle pulse: result_o/cout_o/overflow_o are valid
//   result_o            sum, held until the next accepted start
//   cout_o, overflow_o  carry out of the MSB / two's-complement overflow
//   slice_c0_o          slice carry-in
//   slice_ai_o          slice operand A nibble
//   slice_bi_o          slice operand B nibble
//   slice_s_i           slice sum
//   slice_gg_i          slice group generate
//   slice_gp_i          slice group propagate
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start
// RUN   | driving nibble k_q into the slice, capturing its sum
// DONE  | result valid for one cycle; a start here is accepted

module add32_seq_ctrl #(
  parameter int NIBBLES = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [4*NIBBLES-1:0]   a_i,
  input  logic [4*NIBBLES-1:0]   b_i,
  input  logic                   cin_i,
  input  logic                   sub_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [4*NIBBLES-1:0]   result_o,
  output logic                   cout_o,
  output logic                   overflow_o,
  output logic                   slice_c0_o,
  output logic [3:0]             slice_ai_o,
  output logic [3:0]             slice_bi_o,
  input  logic [3:0]             slice_s_i,
  input  logic                   slice_gg_i,
  input  logic                   slice_gp_i
);

  localparam int W  = 4 * NIBBLES;
  localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  result_q, result_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;

  logic          accept;
  logic          last_nib;
  logic          carry_nxt;
  logic [3:0]    nib_a, nib_b;
  logic [W-1:0]  b_eff;
  logic          cin_eff;

`ifdef ADD32_SUB_EN
  assign b_eff   = sub_i ? ~b_i : b_i;
  assign cin_eff = sub_i ? 1'b1 : cin_i;
`else
  logic sub_unused;
  assign sub_unused = sub_i;
  assign b_eff      = b_i;
  assign cin_eff    = cin_i;
`endif

  // A start is only taken outside RUN, so an in-flight operation is never disturbed.
  assign accept    = start_i && (state_q != ST_RUN);
  assign last_nib  = (k_q == KW'(NIBBLES - 1));
  assign carry_nxt = slice_gg_i | (slice_gp_i & carry_q);

  always_comb begin
    nib_a = 4'h0;
    nib_b = 4'h0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (k_q == KW'(i)) begin
        nib_a = a_q[4*i +: 4];
        nib_b = b_q[4*i +: 4];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          a_d     = a_i;
          b_d     = b_eff;
          carry_d = cin_eff;
          k_d     = '0;
          state_d = ST_RUN;
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        for (int i = 0; i < NIBBLES; i++) begin
          if (k_q == KW'(i)) result_d[4*i +: 4] = slice_s_i;
        end
        carry_d = carry_nxt;
        if (last_nib) begin
          // Final nibble: its slice sum bit 3 is the result sign.
          state_d = ST_DONE;
          cout_d  = carry_nxt;
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (slice_s_i[3] != a_q[W-1]);
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      k_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy_o     = (state_q == ST_RUN);
  assign done_o     = (state_q == ST_DONE);
  assign result_o   = result_q;
  assign cout_o     = cout_q;
  assign overflow_o = ovf_q;
  assign slice_c0_o = busy_o ? carry_q : 1'b0;
  assign slice_ai_o = busy_o ? nib_a : 4'h0;
  assign slice_bi_o = busy_o ? nib_b : 4'h0;

endmodule
